// File: rtl/mp4_mem_subsys_if.sv
// Bus bundle between the mp4 core ports, the memory subsystem and physical memory.
// slave is the subsystem's view; master is the surrounding CPU/memory view.
interface mp4_mem_subsys_if;
    logic        inst_read;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_resp;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_mbe;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [63:0] pmem_rdata;
    logic [63:0] pmem_wdata;
    logic        pmem_resp;

    modport slave (
        input  inst_read, inst_addr, data_read, data_write, data_addr, data_wdata, data_mbe,
               pmem_rdata, pmem_resp,
        output inst_rdata, inst_resp, data_rdata, data_resp,
               pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output inst_read, inst_addr, data_read, data_write, data_addr, data_wdata, data_mbe,
               pmem_rdata, pmem_resp,
        input  inst_rdata, inst_resp, data_rdata, data_resp,
               pmem_address, pmem_read, pmem_write, pmem_wdata
    );
endinterface

// File: rtl/mp4_mem_subsys.sv
// Cacheless memory subsystem: every word request becomes a 4x64-bit line burst;
// stores are line read, byte merge, line write. Data port wins arbitration.
module mp4_mem_subsys (
    input  logic            clk,
    input  logic            rst,
    mp4_mem_subsys_if.slave bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RD_BURST = 2'd1;
    localparam logic [1:0] ST_WR_BURST = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    logic [1:0]   state_r, state_s;
    logic [1:0]   beat_r, beat_s;
    logic [255:0] line_r, line_s;
    logic         sel_data_r, sel_data_s;
    logic         is_store_r, is_store_s;
    logic [31:2]  addr_r, addr_s;
    logic [31:0]  wdata_r, wdata_s;
    logic [3:0]   mbe_r, mbe_s;

    logic [31:0]  inst_rdata_r, inst_rdata_s;
    logic         inst_resp_r, inst_resp_s;
    logic [31:0]  data_rdata_r, data_rdata_s;
    logic         data_resp_r, data_resp_s;
    logic [31:0]  pmem_address_r, pmem_address_s;
    logic         pmem_read_r, pmem_read_s;
    logic         pmem_write_r, pmem_write_s;
    logic [63:0]  pmem_wdata_r, pmem_wdata_s;
    logic [31:0]  resp_word_s;

    // Byte offsets are meaningless for a word-granular port.
    logic unused_s;
    assign unused_s = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

    function automatic logic [31:0] get_word(input logic [255:0] line, input logic [2:0] idx);
        return line[{idx, 5'b00000} +: 32];
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] mbe);
        return {mbe[3] ? new_w[31:24] : old_w[31:24],
                mbe[2] ? new_w[23:16] : old_w[23:16],
                mbe[1] ? new_w[15:8]  : old_w[15:8],
                mbe[0] ? new_w[7:0]   : old_w[7:0]};
    endfunction

    // Next-state logic: arbitration, beat capture, store merge and burst sequencing.
    always_comb begin
        state_s    = state_r;
        beat_s     = beat_r;
        line_s     = line_r;
        sel_data_s = sel_data_r;
        is_store_s = is_store_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        mbe_s      = mbe_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.data_read || bus.data_write) begin
                    sel_data_s = 1'b1;
                    is_store_s = bus.data_write;
                    addr_s     = bus.data_addr[31:2];
                    wdata_s    = bus.data_wdata;
                    mbe_s      = bus.data_mbe;
                    beat_s     = 2'd0;
                    state_s    = ST_RD_BURST;
                end else if (bus.inst_read) begin
                    sel_data_s = 1'b0;
                    is_store_s = 1'b0;
                    addr_s     = bus.inst_addr[31:2];
                    wdata_s    = 32'd0;
                    mbe_s      = 4'd0;
                    beat_s     = 2'd0;
                    state_s    = ST_RD_BURST;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_BURST: begin
                if (bus.pmem_resp) begin
                    line_s[{beat_r, 6'b000000} +: 64] = bus.pmem_rdata;
                    if (beat_r == 2'd3) begin
                        beat_s = 2'd0;
                        if (is_store_r) begin
                            line_s[{addr_r[4:2], 5'b00000} +: 32] =
                                merge_bytes(get_word(line_s, addr_r[4:2]), wdata_r, mbe_r);
                            state_s = ST_WR_BURST;
                        end else begin
                            state_s = ST_RESP;
                        end
                    end else begin
                        beat_s = beat_r + 2'd1;
                    end
                end else begin
                    state_s = ST_RD_BURST;
                end
            end
            ST_WR_BURST: begin
                if (bus.pmem_resp) begin
                    if (beat_r == 2'd3) begin
                        beat_s  = 2'd0;
                        state_s = ST_RESP;
                    end else begin
                        beat_s = beat_r + 2'd1;
                    end
                end else begin
                    state_s = ST_WR_BURST;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        inst_rdata_s   = 32'd0;
        inst_resp_s    = 1'b0;
        data_rdata_s   = 32'd0;
        data_resp_s    = 1'b0;
        pmem_address_s = 32'd0;
        pmem_read_s    = 1'b0;
        pmem_write_s   = 1'b0;
        pmem_wdata_s   = 64'd0;
        resp_word_s    = get_word(line_s, addr_s[4:2]);
        case (state_s)
            ST_IDLE: pmem_read_s = 1'b0;
            ST_RD_BURST: begin
                pmem_read_s    = 1'b1;
                pmem_address_s = {addr_s[31:5], 5'b00000};
            end
            ST_WR_BURST: begin
                pmem_write_s   = 1'b1;
                pmem_address_s = {addr_s[31:5], 5'b00000};
                pmem_wdata_s   = line_s[{beat_s, 6'b000000} +: 64];
            end
            ST_RESP: begin
                if (sel_data_s) begin
                    data_resp_s  = 1'b1;
                    data_rdata_s = resp_word_s;
                end else begin
                    inst_resp_s  = 1'b1;
                    inst_rdata_s = resp_word_s;
                end
            end
            default: pmem_read_s = 1'b0;
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            beat_r         <= 2'd0;
            line_r         <= 256'd0;
            sel_data_r     <= 1'b0;
            is_store_r     <= 1'b0;
            addr_r         <= 30'd0;
            wdata_r        <= 32'd0;
            mbe_r          <= 4'd0;
            inst_rdata_r   <= 32'd0;
            inst_resp_r    <= 1'b0;
            data_rdata_r   <= 32'd0;
            data_resp_r    <= 1'b0;
            pmem_address_r <= 32'd0;
            pmem_read_r    <= 1'b0;
            pmem_write_r   <= 1'b0;
            pmem_wdata_r   <= 64'd0;
        end else begin
            state_r        <= state_s;
            beat_r         <= beat_s;
            line_r         <= line_s;
            sel_data_r     <= sel_data_s;
            is_store_r     <= is_store_s;
            addr_r         <= addr_s;
            wdata_r        <= wdata_s;
            mbe_r          <= mbe_s;
            inst_rdata_r   <= inst_rdata_s;
            inst_resp_r    <= inst_resp_s;
            data_rdata_r   <= data_rdata_s;
            data_resp_r    <= data_resp_s;
            pmem_address_r <= pmem_address_s;
            pmem_read_r    <= pmem_read_s;
            pmem_write_r   <= pmem_write_s;
            pmem_wdata_r   <= pmem_wdata_s;
        end
    end

    assign bus.inst_rdata   = inst_rdata_r;
    assign bus.inst_resp    = inst_resp_r;
    assign bus.data_rdata   = data_rdata_r;
    assign bus.data_resp    = data_resp_r;
    assign bus.pmem_address = pmem_address_r;
    assign bus.pmem_read    = pmem_read_r;
    assign bus.pmem_write   = pmem_write_r;
    assign bus.pmem_wdata   = pmem_wdata_r;
endmodule

// File: tb/tb_mp4_mem_subsys.sv
// Directed bench for mp4_mem_subsys: vector table of word requests against a
// behavioural burst memory, plus hand sequences for wait states, arbitration and reset.
module tb_mp4_mem_subsys;
    logic clk = 1'b0;
    logic rst;
    mp4_mem_subsys_if bus ();

    mp4_mem_subsys dut (.clk(clk), .rst(rst), .bus(bus));

    initial forever #5 clk = ~clk;

    logic [63:0] mem [8][4];
    logic        wait_mode = 1'b0;
    logic [1:0]  mbeat = 2'd0;
    int          mwcnt = 0;
    logic        m_wr = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        logic        is_data;
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic [31:0] exp_rdata;
        logic [31:0] exp_paddr;
        int          exp_cyc;
    } vec_t;
    vec_t vecs [13];

    // Burst memory: answers beats at the negative edge, optionally one beat every 3rd cycle.
    initial begin
        logic go;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 64'd0;
        forever begin
            @(negedge clk);
            if (!bus.pmem_read && !bus.pmem_write) begin
                mbeat = 2'd0;
                mwcnt = 0;
                bus.pmem_resp  = 1'b0;
                bus.pmem_rdata = 64'd0;
            end else begin
                if (bus.pmem_write != m_wr) begin
                    mbeat = 2'd0;
                    mwcnt = 0;
                end
                go = !wait_mode || (mwcnt == 2);
                mwcnt = go ? 0 : mwcnt + 1;
                bus.pmem_resp = go;
                if (go && bus.pmem_write) begin
                    mem[bus.pmem_address[7:5]][mbeat] = bus.pmem_wdata;
                    bus.pmem_rdata = 64'd0;
                    mbeat = mbeat + 2'd1;
                end else if (go) begin
                    bus.pmem_rdata = mem[bus.pmem_address[7:5]][mbeat];
                    mbeat = mbeat + 2'd1;
                end else begin
                    bus.pmem_rdata = 64'd0;
                end
            end
            m_wr = bus.pmem_write;
        end
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one request at a negedge and waits (bounded) for its resp pulse.
    task automatic do_req(input logic is_data, input logic is_wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mbe,
                          output logic [31:0] rdata, output logic [31:0] paddr, output int cyc,
                          output logic other, output logic moved);
        logic got_addr;
        got_addr = 1'b0; paddr = 32'd0; rdata = 32'd0; other = 1'b0; moved = 1'b0;
        if (is_data) begin
            bus.data_read = !is_wr; bus.data_write = is_wr; bus.data_addr = addr;
            bus.data_wdata = wdata; bus.data_mbe = mbe;
        end else begin
            bus.inst_read = 1'b1; bus.inst_addr = addr;
        end
        cyc = 1;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.pmem_read || bus.pmem_write) begin
                if (!got_addr) begin paddr = bus.pmem_address; got_addr = 1'b1; end
                else if (bus.pmem_address != paddr) moved = 1'b1;
            end
            if (is_data ? bus.inst_resp : bus.data_resp) other = 1'b1;
            if (is_data ? bus.data_resp : bus.inst_resp) begin
                rdata = is_data ? bus.data_rdata : bus.inst_rdata;
                break;
            end
        end
        if (cyc >= 200) $display("FAIL timeout: no resp for addr %h", addr);
        bus.inst_read = 1'b0; bus.data_read = 1'b0; bus.data_write = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] rd, pa;
        int          cyc;
        logic        oth, mov;
        do_req(v.is_data, v.is_wr, v.addr, v.wdata, v.mbe, rd, pa, cyc, oth, mov);
        check({tag, " rdata"}, 192'(rd), 192'(v.exp_rdata));
        check({tag, " pmem_address"}, 192'(pa), 192'(v.exp_paddr));
        check({tag, " latency"}, 192'(cyc), 192'(v.exp_cyc));
        check({tag, " other resp"}, 192'(oth), 192'(1'b0));
        check({tag, " address steady"}, 192'(mov), 192'(1'b0));
        @(negedge clk);
        check({tag, " resp pulse width"},
              192'({bus.inst_resp, bus.data_resp, bus.inst_rdata, bus.data_rdata}), 192'(0));
    endtask

    initial begin
        logic [31:0] rd, pa;
        int          cyc, dcyc, icyc;
        logic        oth, mov, overlap;
        logic [31:0] d_rd, i_rd;

        for (int l = 0; l < 8; l++)
            for (int b = 0; b < 4; b++)
                mem[l][b] = {16'hC0C0 + 16'(l), 16'(2 * b + 1), 16'hC0C0 + 16'(l), 16'(2 * b)};
        for (int b = 0; b < 4; b++) begin
            mem[3][b] = {32'h1111_0000 + 32'(b), 32'h2222_0001 + 32'(b)};
            mem[2][b] = 64'hAAAA_AAAA_AAAA_AAAA;
        end

        //            data  wr    addr          wdata         mbe      exp_rdata     paddr         cyc
        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0060, 32'h0,        4'b0000, 32'h2222_0001, 32'h0000_0060, 6};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0,        4'b0000, 32'h1111_0003, 32'h0000_0060, 6};
        vecs[2]  = '{1'b0, 1'b0, 32'h0000_0064, 32'h0,        4'b0000, 32'h1111_0000, 32'h0000_0060, 6};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_002B, 32'h0,        4'b0000, 32'hC0C1_0002, 32'h0000_0020, 6};
        vecs[4]  = '{1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 4'b0101, 32'hAA34_AA78, 32'h0000_0040, 10};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        4'b0000, 32'hAA34_AA78, 32'h0000_0040, 6};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        4'b0000, 32'hAAAA_AAAA, 32'h0000_0040, 6};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_005C, 32'hFFFF_FFFF, 4'b0000, 32'hAAAA_AAAA, 32'h0000_0040, 10};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_005C, 32'h0,        4'b0000, 32'hAAAA_AAAA, 32'h0000_0040, 6};
        vecs[9]  = '{1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 10};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,        4'b0000, 32'hDEAD_BEEF, 32'h0000_0000, 6};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_000C, 32'h9988_7766, 4'b1000, 32'h99C0_0003, 32'h0000_0000, 10};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_000C, 32'h0,        4'b0000, 32'h99C0_0003, 32'h0000_0000, 6};

        rst = 1'b0;
        bus.inst_read = 1'b0; bus.inst_addr = 32'd0;
        bus.data_read = 1'b0; bus.data_write = 1'b0; bus.data_addr = 32'd0;
        bus.data_wdata = 32'd0; bus.data_mbe = 4'd0;
        repeat (3) @(negedge clk);
        check("reset outputs", 192'({bus.inst_rdata, bus.inst_resp, bus.data_rdata, bus.data_resp,
              bus.pmem_address, bus.pmem_read, bus.pmem_write, bus.pmem_wdata}), 192'(0));
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        check("store merge beat0", 192'(mem[2][0]), 192'(64'hAA34AA78_AAAAAAAA));
        check("store untouched beat3", 192'(mem[2][3]), 192'(64'hAAAAAAAA_AAAAAAAA));
        check("store line0 beat1", 192'(mem[0][1]), 192'(64'h99C00003_DEADBEEF));

        // Wait states: one beat every third cycle, 12 burst cycles.
        wait_mode = 1'b1;
        run_vec('{1'b1, 1'b0, 32'h0000_0078, 32'h0, 4'b0000, 32'h2222_0004, 32'h0000_0060, 14}, "wait load");
        run_vec('{1'b0, 1'b0, 32'h0000_0064, 32'h0, 4'b0000, 32'h1111_0000, 32'h0000_0060, 14}, "wait fetch");
        wait_mode = 1'b0;

        // Arbitration: simultaneous requests, data first, instruction right after.
        bus.inst_read = 1'b1; bus.inst_addr = 32'h0000_0060;
        bus.data_read = 1'b1; bus.data_addr = 32'h0000_0044;
        cyc = 1; dcyc = 0; icyc = 0; overlap = 1'b0; d_rd = 32'd0; i_rd = 32'd0;
        while (cyc < 200 && icyc == 0) begin
            @(negedge clk);
            cyc++;
            if (bus.inst_resp && bus.data_resp) overlap = 1'b1;
            if (bus.data_resp) begin dcyc = cyc; d_rd = bus.data_rdata; bus.data_read = 1'b0; end
            if (bus.inst_resp) begin icyc = cyc; i_rd = bus.inst_rdata; bus.inst_read = 1'b0; end
        end
        bus.inst_read = 1'b0; bus.data_read = 1'b0;
        check("arb data cycle", 192'(dcyc), 192'(6));
        check("arb inst cycle", 192'(icyc), 192'(12));
        check("arb data rdata", 192'(d_rd), 192'(32'hAA34_AA78));
        check("arb inst rdata", 192'(i_rd), 192'(32'h2222_0001));
        check("arb resp overlap", 192'(overlap), 192'(1'b0));
        @(negedge clk);

        // Request still held through its resp cycle must not restart a burst.
        bus.inst_read = 1'b1; bus.inst_addr = 32'h0000_0060;
        repeat (6) @(negedge clk);
        check("held after resp no reservice", 192'({bus.pmem_read, bus.inst_resp}), 192'(0));
        bus.inst_read = 1'b0;
        @(negedge clk);

        // Reset during beat 2 of a read burst.
        bus.inst_read = 1'b1; bus.inst_addr = 32'h0000_0060;
        repeat (3) @(negedge clk);
        check("burst active before reset", 192'(bus.pmem_read), 192'(1'b1));
        rst = 1'b0;
        @(negedge clk);
        check("mid-burst reset outputs", 192'({bus.inst_rdata, bus.inst_resp, bus.data_rdata,
              bus.data_resp, bus.pmem_address, bus.pmem_read, bus.pmem_write, bus.pmem_wdata}), 192'(0));
        bus.inst_read = 1'b0;
        rst = 1'b1;
        run_vec('{1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'b0000, 32'hC0C0_0000, 32'h0000_0000, 6}, "post-reset fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mp4_mem_subsys.md
Name: mp4_mem_subsys

Overview:
- Memory-side block of the mp4 out-of-order RISC-V core.
- Arbitrates between the CPU instruction port and the CPU data port.
- Serves each 32-bit word request through a 256-bit line transfer on the physical memory port, as 4 beats of 64 bits.
- Has no cache storage: every request is a full line transaction. Data writes are performed as line read, byte merge, line write.

Parameters:
- None. Fixed values: line = 256 bits (32 B), burst = 4 beats x 64 bits, addresses 32 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- inst_read  in  1  instruction fetch request; held until inst_resp.
- inst_addr  in  32  fetch byte address; bits [1:0] ignored.
- inst_rdata  out  32  fetched word; valid while inst_resp=1.
- inst_resp  out  1  one-cycle completion pulse for the instruction port.
- data_read  in  1  data load request; held until data_resp.
- data_write  in  1  data store request; held until data_resp. Never asserted together with data_read.
- data_addr  in  32  data byte address; bits [1:0] ignored.
- data_wdata  in  32  store data.
- data_mbe  in  4  store byte enables; bit i enables byte i of data_wdata.
- data_rdata  out  32  load word; valid while data_resp=1.
- data_resp  out  1  one-cycle completion pulse for the data port.
- pmem_address  out  32  line-aligned address: {addr[31:5], 5'b0}.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_rdata  in  64  read beat; valid when pmem_resp=1.
- pmem_wdata  out  64  write beat.
- pmem_resp  in  1  one beat accepted or delivered per asserted cycle.

Behaviour:
- Reset (rst=0 at a clock edge):
  - FSM goes to IDLE, beat counter = 0, line buffer cleared.
  - All outputs = 0.
  - A reset mid-burst abandons the transfer; pmem_read and pmem_write drop the following cycle.
- FSM states: IDLE, RD_BURST, WR_BURST, RESP.
- IDLE:
  - Data request has priority over instruction request when both are pending.
  - On acceptance, latch the port select, address, wdata and mbe. Go to RD_BURST with beat counter = 0.
- RD_BURST:
  - Hold pmem_read=1 with pmem_address fixed.
  - On each pmem_resp, store pmem_rdata into line bits [64k+63:64k], where k = beat counter (beat 0 = lowest bytes), then increment k.
  - After beat 3: a load or fetch goes to RESP. A store merges data_wdata into word addr[4:2] under data_mbe, then goes to WR_BURST with k = 0.
- WR_BURST:
  - Hold pmem_write=1 and pmem_wdata = line beat k.
  - Advance k on each pmem_resp; after beat 3 go to RESP.
- RESP:
  - Exactly one cycle.
  - Assert the latched port's resp. rdata = line word addr[4:2] (stores return the merged word).
  - Next state is always IDLE, so a request still held during the resp cycle is not re-serviced. The earliest next acceptance is the IDLE cycle after RESP.
- Signal exclusivity:
  - pmem_read and pmem_write are never both 1.
  - inst_resp and data_resp are never both 1.
- Deasserted outputs:
  - rdata outputs are 0 when their resp is 0.
  - pmem_address is 0 in IDLE/RESP.
- Stalls: a beat with pmem_resp=0 is a stall; there is no timeout.
- Latency:
  - Read = 1 accept cycle + 4 or more beat cycles + 1 resp cycle.
  - Store = read latency + 4 or more write-beat cycles.
- Request changes: address or request changes after acceptance are ignored until RESP.
- Byte masking: a data_mbe of 0 on a store still performs both bursts and writes the line back unchanged.
- Instruction fairness: instruction requests are not starved beyond one data transaction once data traffic stops. No further fairness is guaranteed.

Test Plan:
- Fetch: inst_read, inst_addr=0x60. Memory line 0x60 beats = 0x1111_0000_2222_0001, ... -> pmem_read with pmem_address=0x60. inst_rdata = low word of beat 0 = 0x2222_0001, inst_resp for 1 cycle, 6 cycles total at zero-wait.
- Load word select: data_read, addr=0x7C -> pmem_address=0x60, data_rdata = upper 32 bits of beat 3, data_resp pulse, inst_resp stays 0.
- Store merge: line at 0x40 all 0xAA. Store data_addr=0x44, wdata=0x12345678, mbe=4'b0101 -> beat 0 written as 0xAA34AA78_AAAAAAAA. Other beats unchanged, data_resp after the write burst.
- Arbitration: inst_read and data_read asserted on the same cycle -> data serviced first, instruction serviced next, no request lost, resps non-overlapping.
- Wait states: pmem_resp pulsed every 3rd cycle -> correct beat ordering, pmem_read held steady throughout, resp only after the 4th beat.
- Reset mid-burst: rst=0 during beat 2 of RD_BURST -> the next cycle all outputs are 0. After release, a new fetch to 0x0 completes normally.
